// File: rtl/param_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : param_branch_predictor
// Brief    : Two-level branch predictor (local PAg or gshare) with a tagged,
//            direct-mapped BTB and saturating branch/mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module param_branch_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int LHT_ENTRIES = 64,
    parameter int HIST_BITS   = 4,
    parameter int CTR_BITS    = 2,
    parameter int GLOBAL      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcf,
    output logic        hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int c_BTB_IW      = $clog2(BTB_ENTRIES);
    localparam int c_LHT_IW      = $clog2(LHT_ENTRIES);
    localparam int c_TAG_W       = 30 - c_BTB_IW;
    localparam int c_PHT_ENTRIES = 1 << HIST_BITS;
    localparam logic [CTR_BITS-1:0] c_CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] c_CTR_MAX  = '1;

    logic                r_btb_valid  [BTB_ENTRIES];
    logic [c_TAG_W-1:0]  r_btb_tag    [BTB_ENTRIES];
    logic [31:0]         r_btb_target [BTB_ENTRIES];
    logic [CTR_BITS-1:0] r_pht        [c_PHT_ENTRIES];
    logic [31:0]         r_branch_cnt;
    logic [31:0]         r_mispred_cnt;

    logic [c_BTB_IW-1:0]  w_lk_btb_idx;
    logic [c_BTB_IW-1:0]  w_upd_btb_idx;
    logic [c_TAG_W-1:0]   w_lk_tag;
    logic [c_TAG_W-1:0]   w_upd_tag;
    logic [HIST_BITS-1:0] w_lk_pht_idx;
    logic [HIST_BITS-1:0] w_upd_pht_idx;
    logic [HIST_BITS-1:0] w_upd_hist;
    logic [HIST_BITS-1:0] w_hist_next;
    logic [CTR_BITS-1:0]  w_upd_ctr;
    logic                 w_lk_hit;
    logic                 w_unused_pc_bits;

    assign w_lk_btb_idx  = pcf[c_BTB_IW+1:2];
    assign w_lk_tag      = pcf[31:c_BTB_IW+2];
    assign w_upd_btb_idx = upd_pc[c_BTB_IW+1:2];
    assign w_upd_tag     = upd_pc[31:c_BTB_IW+2];
    assign w_unused_pc_bits = ^{pcf[1:0], upd_pc[1:0]};

    // History register(s) live in the mode-specific branch; both expose the
    // pre-update history and the PHT indices derived from it.
    generate
        if (GLOBAL == 0) begin : g_local
            logic [HIST_BITS-1:0] r_lht [LHT_ENTRIES];
            logic [c_LHT_IW-1:0]  w_lk_lht_idx;
            logic [c_LHT_IW-1:0]  w_upd_lht_idx;

            assign w_lk_lht_idx  = pcf[c_LHT_IW+1:2];
            assign w_upd_lht_idx = upd_pc[c_LHT_IW+1:2];
            assign w_lk_pht_idx  = r_lht[w_lk_lht_idx];
            assign w_upd_hist    = r_lht[w_upd_lht_idx];
            assign w_upd_pht_idx = w_upd_hist;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < LHT_ENTRIES; i++) begin
                        r_lht[i] <= '0;
                    end
                end else if (upd_valid) begin
                    r_lht[w_upd_lht_idx] <= w_hist_next;
                end
            end
        end else begin : g_global
            logic [HIST_BITS-1:0] r_ghr;

            assign w_lk_pht_idx  = r_ghr ^ pcf[HIST_BITS+1:2];
            assign w_upd_hist    = r_ghr;
            assign w_upd_pht_idx = r_ghr ^ upd_pc[HIST_BITS+1:2];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ghr <= '0;
                end else if (upd_valid) begin
                    r_ghr <= w_hist_next;
                end
            end
        end
    endgenerate

    generate
        if (HIST_BITS == 1) begin : g_hist_one
            assign w_hist_next = upd_taken;
        end else begin : g_hist_shift
            assign w_hist_next = {w_upd_hist[HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    assign w_upd_ctr = r_pht[w_upd_pht_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_PHT_ENTRIES; i++) begin
                r_pht[i] <= c_CTR_INIT;
            end
        end else if (upd_valid) begin
            if (upd_taken && (w_upd_ctr != c_CTR_MAX)) begin
                r_pht[w_upd_pht_idx] <= w_upd_ctr + CTR_BITS'(1);
            end else if (!upd_taken && (w_upd_ctr != '0)) begin
                r_pht[w_upd_pht_idx] <= w_upd_ctr - CTR_BITS'(1);
            end
        end
    end

    // Not-taken resolutions leave the BTB alone; a taken one evicts any alias.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb_valid[i]  <= 1'b0;
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            r_btb_valid[w_upd_btb_idx]  <= 1'b1;
            r_btb_tag[w_upd_btb_idx]    <= w_upd_tag;
            r_btb_target[w_upd_btb_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (upd_valid) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if ((upd_pred != upd_taken) && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign w_lk_hit    = r_btb_valid[w_lk_btb_idx] && (r_btb_tag[w_lk_btb_idx] == w_lk_tag);
    assign hit         = w_lk_hit;
    assign pred_taken  = w_lk_hit & r_pht[w_lk_pht_idx][CTR_BITS-1];
    assign pred_target = w_lk_hit ? r_btb_target[w_lk_btb_idx] : 32'd0;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_param_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_branch_predictor
// Brief    : Scoreboard bench for the local (GLOBAL=0) and gshare (GLOBAL=1)
//            predictor configurations using hand-computed directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] pcf_l, upd_pc_l, upd_target_l, pred_target_l, branch_cnt_l, mispred_cnt_l;
    logic        hit_l, pred_taken_l, upd_valid_l, upd_taken_l, upd_pred_l;
    logic [31:0] pcf_g, upd_pc_g, upd_target_g, pred_target_g, branch_cnt_g, mispred_cnt_g;
    logic        hit_g, pred_taken_g, upd_valid_g, upd_taken_g, upd_pred_g;

    always #5 clk = ~clk;

    param_branch_predictor #(.GLOBAL(0)) dut (
        .clk(clk), .reset(reset), .pcf(pcf_l),
        .hit(hit_l), .pred_taken(pred_taken_l), .pred_target(pred_target_l),
        .upd_valid(upd_valid_l), .upd_pc(upd_pc_l), .upd_taken(upd_taken_l),
        .upd_target(upd_target_l), .upd_pred(upd_pred_l),
        .branch_cnt(branch_cnt_l), .mispred_cnt(mispred_cnt_l)
    );

    param_branch_predictor #(.GLOBAL(1)) dut_g (
        .clk(clk), .reset(reset), .pcf(pcf_g),
        .hit(hit_g), .pred_taken(pred_taken_g), .pred_target(pred_target_g),
        .upd_valid(upd_valid_g), .upd_pc(upd_pc_g), .upd_taken(upd_taken_g),
        .upd_target(upd_target_g), .upd_pred(upd_pred_g),
        .branch_cnt(branch_cnt_g), .mispred_cnt(mispred_cnt_g)
    );

    // kind: 0 = local outputs, 1 = gshare outputs, 2 = local PHT, 3 = gshare PHT
    typedef struct {
        int          kind;
        string       name;
        logic        hit;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
        int          idx;
        logic [1:0]  ctr;
    } exp_t;

    exp_t        sb_q[$];
    event        ev_chk;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_bl = 0, exp_ml = 0, exp_bg = 0, exp_mg = 0;

    initial begin : monitor
        exp_t        e;
        logic [97:0] act, req;
        logic [1:0]  act_ctr;
        forever begin
            @(ev_chk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (e.kind < 2) begin
                    req = {e.hit, e.tk, e.tgt, e.bcnt, e.mcnt};
                    act = (e.kind == 0)
                        ? {hit_l, pred_taken_l, pred_target_l, branch_cnt_l, mispred_cnt_l}
                        : {hit_g, pred_taken_g, pred_target_g, branch_cnt_g, mispred_cnt_g};
                    if (act !== req) begin
                        n_err++;
                        $display("FAIL %s: got hit=%b tk=%b tgt=%h b=%h m=%h, want hit=%b tk=%b tgt=%h b=%h m=%h",
                                 e.name, act[97], act[96], act[95:64], act[63:32], act[31:0],
                                 req[97], req[96], req[95:64], req[63:32], req[31:0]);
                    end
                end else begin
                    act_ctr = (e.kind == 2) ? dut.r_pht[e.idx] : dut_g.r_pht[e.idx];
                    if (act_ctr !== e.ctr) begin
                        n_err++;
                        $display("FAIL %s: got pht[%0d]=%0d, want %0d", e.name, e.idx, act_ctr, e.ctr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_out(input int kind, input string name, input logic [31:0] pc,
                           input logic h, input logic tk, input logic [31:0] tgt);
        exp_t e;
        if (kind == 0) pcf_l = pc; else pcf_g = pc;
        #1;
        e.kind = kind; e.name = name; e.hit = h; e.tk = tk; e.tgt = tgt;
        e.bcnt = (kind == 0) ? exp_bl : exp_bg;
        e.mcnt = (kind == 0) ? exp_ml : exp_mg;
        e.idx = 0; e.ctr = 2'd0;
        sb_q.push_back(e);
        ->ev_chk;
        #1;
    endtask

    task automatic chk_pht(input int kind, input string name, input int idx, input logic [1:0] ctr);
        exp_t e;
        e.kind = kind; e.name = name; e.hit = 1'b0; e.tk = 1'b0; e.tgt = '0;
        e.bcnt = '0; e.mcnt = '0; e.idx = idx; e.ctr = ctr;
        sb_q.push_back(e);
        ->ev_chk;
        #1;
    endtask

    task automatic upd_l(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pred);
        upd_valid_l = 1'b1; upd_pc_l = pc; upd_taken_l = tk; upd_target_l = tgt; upd_pred_l = pred;
        tick();
        upd_valid_l = 1'b0;
        exp_bl = sat_inc(exp_bl);
        if (pred != tk) exp_ml = sat_inc(exp_ml);
    endtask

    task automatic upd_g(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pred);
        upd_valid_g = 1'b1; upd_pc_g = pc; upd_taken_g = tk; upd_target_g = tgt; upd_pred_g = pred;
        tick();
        upd_valid_g = 1'b0;
        exp_bg = sat_inc(exp_bg);
        if (pred != tk) exp_mg = sat_inc(exp_mg);
    endtask

    initial begin : stimulus
        reset = 1'b1;
        pcf_l = 32'h0040_0010; upd_valid_l = 0; upd_pc_l = 0; upd_taken_l = 0; upd_target_l = 0; upd_pred_l = 0;
        pcf_g = 32'h0040_0010; upd_valid_g = 0; upd_pc_g = 0; upd_taken_g = 0; upd_target_g = 0; upd_pred_g = 0;
        #12;
        reset = 1'b0;

        chk_out(0, "reset_lookup", 32'h0040_0010, 0, 0, 32'h0);
        chk_out(1, "reset_lookup_g", 32'h0040_0010, 0, 0, 32'h0);

        // Train 0x00400010: LHT[4] walks 0001,0011,0111,1111.
        upd_l(32'h0040_0010, 1, 32'h0040_0040, 0);
        chk_out(0, "first_taken", 32'h0040_0010, 1, 0, 32'h0040_0040);
        for (int i = 0; i < 3; i++) upd_l(32'h0040_0010, 1, 32'h0040_0040, 0);
        chk_out(0, "after_4th", 32'h0040_0010, 1, 0, 32'h0040_0040);
        upd_l(32'h0040_0010, 1, 32'h0040_0040, 0);
        chk_out(0, "after_5th", 32'h0040_0010, 1, 1, 32'h0040_0040);
        chk_pht(2, "pht_0000", 0, 2'd2);
        chk_pht(2, "pht_0111", 7, 2'd2);

        chk_out(0, "alias_miss", 32'h0040_0110, 0, 0, 32'h0);
        upd_l(32'h0040_0110, 1, 32'h0040_0200, 1);
        chk_out(0, "alias_evicted", 32'h0040_0010, 0, 0, 32'h0);
        chk_out(0, "alias_new", 32'h0040_0110, 1, 1, 32'h0040_0200);

        // Lookup and update of the same PC in one cycle sees pre-update state.
        pcf_l = 32'h0040_0020;
        upd_valid_l = 1'b1; upd_pc_l = 32'h0040_0020; upd_taken_l = 1'b1;
        upd_target_l = 32'h0040_0080; upd_pred_l = 1'b0;
        chk_out(0, "collide_same_cycle", 32'h0040_0020, 0, 0, 32'h0);
        tick();
        upd_valid_l = 1'b0;
        exp_bl = sat_inc(exp_bl); exp_ml = sat_inc(exp_ml);
        chk_out(0, "collide_next_cycle", 32'h0040_0020, 1, 1, 32'h0040_0080);

        for (int i = 0; i < 10; i++) upd_l(32'h0040_0030, 0, 32'h0040_0900, 0);
        chk_pht(2, "pht_sat_low", 0, 2'd0);
        chk_out(0, "nt_no_btb_write", 32'h0040_0030, 0, 0, 32'h0);
        upd_l(32'h0040_0110, 1, 32'h0040_0200, 1);
        chk_pht(2, "pht_sat_high", 15, 2'd3);

        force dut.r_branch_cnt  = 32'hFFFF_FFFF;
        force dut.r_mispred_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_branch_cnt;
        release dut.r_mispred_cnt;
        exp_bl = 32'hFFFF_FFFF; exp_ml = 32'hFFFF_FFFF;
        upd_l(32'h0040_0110, 1, 32'h0040_0200, 0);
        chk_out(0, "cnt_saturate", 32'h0040_0110, 1, 1, 32'h0040_0200);

        // Asynchronous reset mid-cycle, then an update held across a reset edge.
        reset = 1'b1;
        exp_bl = 0; exp_ml = 0; exp_bg = 0; exp_mg = 0;
        chk_out(0, "async_reset", 32'h0040_0110, 0, 0, 32'h0);
        upd_valid_l = 1'b1; upd_pc_l = 32'h0040_0050; upd_taken_l = 1'b1;
        upd_target_l = 32'h0040_0500; upd_pred_l = 1'b0;
        tick();
        reset = 1'b0;
        upd_valid_l = 1'b0;
        chk_out(0, "upd_during_reset", 32'h0040_0050, 0, 0, 32'h0);
        chk_pht(2, "pht_reset", 15, 2'd1);

        // gshare: A = 0x00400010 (pc[5:2]=0100), B = 0x00400024 (pc[5:2]=1001).
        upd_g(32'h0040_0010, 1, 32'h0040_0100, 0);
        upd_g(32'h0040_0024, 0, 32'h0040_0300, 0);
        upd_g(32'h0040_0010, 1, 32'h0040_0100, 0);
        upd_g(32'h0040_0024, 0, 32'h0040_0300, 0);
        chk_pht(3, "g_pht_0100", 4, 2'd2);
        chk_pht(3, "g_pht_1000", 8, 2'd0);
        chk_pht(3, "g_pht_0110", 6, 2'd2);
        chk_pht(3, "g_pht_1100", 12, 2'd0);
        chk_pht(3, "g_pht_0000", 0, 2'd1);
        chk_out(1, "g_lookup_A_1110", 32'h0040_0010, 1, 0, 32'h0040_0100);
        chk_out(1, "g_lookup_B_miss", 32'h0040_0024, 0, 0, 32'h0);
        upd_g(32'h0040_0010, 1, 32'h0040_0100, 0);
        chk_pht(3, "g_pht_1110", 14, 2'd2);
        chk_out(1, "g_lookup_A_0001", 32'h0040_0010, 1, 0, 32'h0040_0100);
        upd_g(32'h0040_0024, 0, 32'h0040_0300, 0);
        chk_out(1, "g_lookup_A_taken", 32'h0040_0010, 1, 1, 32'h0040_0100);
        chk_pht(3, "g_pht_1100_sat", 12, 2'd0);

        #5;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
